ctrl_sequencer: RTL and testbench

Parametrised control sequencer for the CPU: owns the fetch/execute state machine that the instruction decoder previously took as an external input. It also owns the condition-code evaluation, a configurable multi-cycle multiply wait, and a hardware stack-depth tracker with overflow/underflow halt. It sits between the decoder's instruction-class outputs and the datapath enables (PC, register file, data RAM write).

---
 rtl/ctrl_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/execute control FSM for the CPU. Evaluates the
// instruction condition code, stretches multiplies over a fixed number of
// execute cycles, and tracks stack depth with a halt on overflow/underflow.
module ctrl_sequencer #(
    parameter  int COND_IDX_W  = 3,
    parameter  int ALWAYS_IDX  = 6,
    parameter  int MUL_CYCLES  = 4,
    parameter  int STACK_DEPTH = 16,
    localparam int STATUS_W    = 2**COND_IDX_W,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_ready,
    input  logic [STATUS_W-1:0]   status_reg,
    input  logic [COND_IDX_W:0]   cond_code,
    input  logic                  is_ext,
    input  logic                  is_mul,
    input  logic                  is_push,
    input  logic                  is_call,
    input  logic                  is_pop,
    input  logic                  is_rtn,
    input  logic                  is_stp,
    input  logic                  resume,
    output logic [2:0]            state,
    output logic                  pc_cnt_en,
    output logic                  cond_true,
    output logic                  commit,
    output logic                  mul_busy,
    output logic [SP_W-1:0]       sp,
    output logic                  halted,
    output logic [1:0]            halt_cause
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'b000,
        ST_EXEC1 = 3'b001,
        ST_EXEC2 = 3'b010,
        ST_MULW  = 3'b011,
        ST_HALT  = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_STP  = 2'b01,
        CAUSE_OVF  = 2'b10,
        CAUSE_UNF  = 2'b11
    } cause_t;

    // Counter holds the remaining MULW cycles minus one; it is loaded with
    // MUL_CYCLES-2 because EXEC1 already accounts for one execute cycle.
    localparam int                    CNT_W       = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
    localparam logic [CNT_W-1:0]      MUL_LOAD    = (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : '0;
    localparam logic                  MUL_WAIT    = (MUL_CYCLES > 1);
    localparam logic [SP_W-1:0]       SP_FULL     = SP_W'(STACK_DEPTH);
    localparam logic [COND_IDX_W-1:0] ALWAYS_CODE = COND_IDX_W'(ALWAYS_IDX);

    state_t           state_q;
    cause_t           cause_q;
    logic [CNT_W-1:0] mul_cnt;
    logic [SP_W-1:0]  sp_q;

    logic [COND_IDX_W-1:0] cond_idx;
    logic                  cond_inv;
    logic                  grow;
    logic                  shrink;
    logic                  stop_hit;
    logic                  ovf_hit;
    logic                  unf_hit;
    logic                  halt_hit;
    logic                  mul_go;

    assign cond_idx = cond_code[COND_IDX_W-1:0];
    assign cond_inv = cond_code[COND_IDX_W];

    // The always index reads true with either invert setting: the inverted
    // form is reserved and must never turn into "never".
    assign cond_true = (cond_idx == ALWAYS_CODE) ? 1'b1 : (status_reg[cond_idx] ^ cond_inv);

    // EXEC1 decode terms, only meaningful while state_q == ST_EXEC1.
    assign grow     = (is_push | is_call) & cond_true;
    assign shrink   = (is_pop | is_rtn) & cond_true;
    assign stop_hit = is_stp & cond_true;
    assign ovf_hit  = grow & (sp_q == SP_FULL);
    assign unf_hit  = shrink & (sp_q == '0);
    assign halt_hit = stop_hit | ovf_hit | unf_hit;
    assign mul_go   = is_mul & cond_true & MUL_WAIT;

    // Sequencer state, halt cause, multiply counter and stack depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
            mul_cnt <= '0;
            sp_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values of the others, independent of statement order.
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) state_q <= ST_EXEC1;
                end
                ST_EXEC1: begin
                    if (stop_hit) begin
                        state_q <= ST_HALT;
                        cause_q <= CAUSE_STP;
                    end else if (ovf_hit) begin
                        state_q <= ST_HALT;
                        cause_q <= CAUSE_OVF;
                    end else if (unf_hit) begin
                        state_q <= ST_HALT;
                        cause_q <= CAUSE_UNF;
                    end else begin
                        if (grow) begin
                            sp_q <= sp_q + SP_W'(1);
                        end else if (shrink) begin
                            sp_q <= sp_q - SP_W'(1);
                        end
                        // The immediate word is skipped even when the
                        // condition is false, so is_ext wins over is_mul.
                        if (is_ext) begin
                            state_q <= ST_EXEC2;
                        end else if (mul_go) begin
                            state_q <= ST_MULW;
                            mul_cnt <= MUL_LOAD;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_EXEC2: begin
                    state_q <= ST_FETCH;
                end
                ST_MULW: begin
                    if (mul_cnt == '0) begin
                        state_q <= ST_FETCH;
                    end else begin
                        mul_cnt <= mul_cnt - CNT_W'(1);
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state_q <= ST_FETCH;
                        cause_q <= CAUSE_NONE;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    // Datapath strobes decoded from the current state; one cycle per event.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a strobe
        // unassigned, which would otherwise infer a latch.
        pc_cnt_en = 1'b0;
        commit    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                pc_cnt_en = mem_ready;
            end
            ST_EXEC1: begin
                if (!halt_hit) begin
                    if (is_ext) begin
                        pc_cnt_en = 1'b1;
                    end else if (!mul_go) begin
                        pc_cnt_en = 1'b1;
                        commit    = cond_true;
                    end
                end
            end
            ST_EXEC2: begin
                commit = cond_true;
            end
            ST_MULW: begin
                if (mul_cnt == '0) begin
                    pc_cnt_en = 1'b1;
                    commit    = 1'b1;
                end
            end
            default: begin
                pc_cnt_en = 1'b0;
                commit    = 1'b0;
            end
        endcase
    end

    assign state      = state_q;
    assign mul_busy   = (state_q == ST_MULW);
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = cause_q;
    assign sp         = sp_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: directed scenarios followed by random
// instructions, each checked cycle by cycle against an instruction-level model.
module tb_ctrl_sequencer;

    localparam int COND_IDX_W  = 3;
    localparam int ALWAYS_IDX  = 6;
    localparam int MUL_CYCLES  = 4;
    localparam int STACK_DEPTH = 16;
    localparam int STATUS_W    = 8;
    localparam int SP_W        = 5;

    localparam logic [2:0] S_FETCH = 3'b000;
    localparam logic [2:0] S_EXEC1 = 3'b001;
    localparam logic [2:0] S_EXEC2 = 3'b010;
    localparam logic [2:0] S_MULW  = 3'b011;
    localparam logic [2:0] S_HALT  = 3'b100;

    typedef struct packed {
        logic ext;
        logic mul;
        logic push;
        logic call;
        logic pop;
        logic rtn;
        logic stp;
    } instr_t;

    localparam instr_t I_PLAIN = '0;
    localparam instr_t I_EXT   = '{ext: 1'b1, default: 1'b0};
    localparam instr_t I_MUL   = '{mul: 1'b1, default: 1'b0};
    localparam instr_t I_PUSH  = '{push: 1'b1, default: 1'b0};
    localparam instr_t I_CALL  = '{call: 1'b1, default: 1'b0};
    localparam instr_t I_POP   = '{pop: 1'b1, default: 1'b0};
    localparam instr_t I_RTN   = '{rtn: 1'b1, default: 1'b0};
    localparam instr_t I_STP   = '{stp: 1'b1, default: 1'b0};

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  mem_ready;
    logic [STATUS_W-1:0]   status_reg;
    logic [COND_IDX_W:0]   cond_code;
    logic                  is_ext, is_mul, is_push, is_call, is_pop, is_rtn, is_stp;
    logic                  resume;
    logic [2:0]            state;
    logic                  pc_cnt_en, cond_true, commit, mul_busy, halted;
    logic [SP_W-1:0]       sp;
    logic [1:0]            halt_cause;

    int n_checks = 0;
    int n_errors = 0;
    int m_sp     = 0;
    int m_cause  = 0;

    ctrl_sequencer #(
        .COND_IDX_W (COND_IDX_W),
        .ALWAYS_IDX (ALWAYS_IDX),
        .MUL_CYCLES (MUL_CYCLES),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_ready (mem_ready),
        .status_reg(status_reg),
        .cond_code (cond_code),
        .is_ext    (is_ext),
        .is_mul    (is_mul),
        .is_push   (is_push),
        .is_call   (is_call),
        .is_pop    (is_pop),
        .is_rtn    (is_rtn),
        .is_stp    (is_stp),
        .resume    (resume),
        .state     (state),
        .pc_cnt_en (pc_cnt_en),
        .cond_true (cond_true),
        .commit    (commit),
        .mul_busy  (mul_busy),
        .sp        (sp),
        .halted    (halted),
        .halt_cause(halt_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Condition rule: index ALWAYS_IDX is true regardless of the invert bit,
    // otherwise the selected status bit XOR the invert bit.
    function automatic logic ref_cond(input logic [3:0] code, input logic [7:0] st);
        int idx;
        int inv;
        idx = int'(code) % STATUS_W;
        inv = int'(code) / STATUS_W;
        if (idx == ALWAYS_IDX) return 1'b1;
        return logic'(((int'(st) >> idx) & 1) ^ inv);
    endfunction

    task automatic drive_instr(input instr_t ins);
        is_ext  = ins.ext;
        is_mul  = ins.mul;
        is_push = ins.push;
        is_call = ins.call;
        is_pop  = ins.pop;
        is_rtn  = ins.rtn;
        is_stp  = ins.stp;
    endtask

    // One clock cycle: sample on the falling edge, then advance past the next rising edge.
    task automatic step(input string tag, input logic [2:0] exp_state,
                        input logic exp_pc, input logic exp_commit);
        @(negedge clk);
        check({tag, ":state"},  state,      exp_state);
        check({tag, ":pc"},     pc_cnt_en,  exp_pc);
        check({tag, ":commit"}, commit,     exp_commit);
        check({tag, ":cond"},   cond_true,  ref_cond(cond_code, status_reg));
        check({tag, ":busy"},   mul_busy,   exp_state == S_MULW);
        check({tag, ":halted"}, halted,     exp_state == S_HALT);
        check({tag, ":sp"},     sp,         m_sp);
        check({tag, ":cause"},  halt_cause, m_cause);
        @(posedge clk);
        #1;
    endtask

    task automatic halt_path(input string tag, input int cause, input int wait_cycles);
        step({tag, "/exec1"}, S_EXEC1, 1'b0, 1'b0);
        m_cause = cause;
        for (int i = 0; i < wait_cycles; i++) begin
            mem_ready = 1'($urandom);
            drive_instr(instr_t'($urandom));
            step({tag, "/halt"}, S_HALT, 1'b0, 1'b0);
        end
        resume = 1'b1;
        step({tag, "/resume"}, S_HALT, 1'b0, 1'b0);
        resume  = 1'b0;
        m_cause = 0;
    endtask

    // Runs one instruction from its first FETCH cycle to its return to FETCH.
    task automatic run_instr(input string tag, input instr_t ins, input logic [3:0] cc,
                             input logic [7:0] st, input int stalls, input int halt_wait);
        logic c;
        logic grow;
        logic shrink;
        cond_code  = cc;
        status_reg = st;
        resume     = 1'b0;
        drive_instr(ins);
        c      = ref_cond(cc, st);
        grow   = (ins.push | ins.call) & c;
        shrink = (ins.pop | ins.rtn) & c;
        mem_ready = 1'b0;
        for (int i = 0; i < stalls; i++) step({tag, "/stall"}, S_FETCH, 1'b0, 1'b0);
        mem_ready = 1'b1;
        step({tag, "/fetch"}, S_FETCH, 1'b1, 1'b0);
        mem_ready = 1'($urandom);
        if (ins.stp && c) begin
            halt_path(tag, 1, halt_wait);
        end else if (grow && m_sp == STACK_DEPTH) begin
            halt_path(tag, 2, halt_wait);
        end else if (shrink && m_sp == 0) begin
            halt_path(tag, 3, halt_wait);
        end else if (ins.ext) begin
            step({tag, "/exec1"}, S_EXEC1, 1'b1, 1'b0);
            m_sp = m_sp + (grow ? 1 : 0) - (shrink ? 1 : 0);
            step({tag, "/exec2"}, S_EXEC2, 1'b0, c);
        end else if (ins.mul && c && MUL_CYCLES > 1) begin
            step({tag, "/exec1"}, S_EXEC1, 1'b0, 1'b0);
            m_sp = m_sp + (grow ? 1 : 0) - (shrink ? 1 : 0);
            for (int k = 1; k < MUL_CYCLES; k++) begin
                step({tag, "/mulw"}, S_MULW, k == MUL_CYCLES - 1, k == MUL_CYCLES - 1);
            end
        end else begin
            step({tag, "/exec1"}, S_EXEC1, 1'b1, c);
            m_sp = m_sp + (grow ? 1 : 0) - (shrink ? 1 : 0);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        instr_t ins;
        reset_n    = 1'b0;
        mem_ready  = 1'b0;
        status_reg = '0;
        cond_code  = '0;
        resume     = 1'b0;
        drive_instr(I_PLAIN);
        #12;
        check("reset:state",  state,      S_FETCH);
        check("reset:sp",     sp,         0);
        check("reset:cause",  halt_cause, 0);
        check("reset:pc",     pc_cnt_en,  0);
        check("reset:commit", commit,     0);
        check("reset:busy",   mul_busy,   0);
        check("reset:halted", halted,     0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Underflow from an empty stack, then the basic condition cases.
        run_instr("pop0",    I_POP,   4'b0110, 8'h00, 0, 2);
        run_instr("plain",   I_PLAIN, 4'b0110, 8'h00, 0, 0);
        run_instr("cond_f",  I_PLAIN, 4'b1000, 8'h01, 0, 0);
        run_instr("cond_t",  I_PLAIN, 4'b0000, 8'h01, 0, 0);
        run_instr("cond_rs", I_PLAIN, 4'b1110, 8'h00, 0, 0);
        run_instr("stp_f",   I_STP,   4'b1000, 8'h01, 0, 0);
        run_instr("stp_t",   I_STP,   4'b0110, 8'h00, 0, 1);
        run_instr("mul",     I_MUL,   4'b0110, 8'h00, 0, 0);
        run_instr("ext",     I_EXT,   4'b1000, 8'h01, 0, 0);
        run_instr("stall",   I_PLAIN, 4'b0110, 8'h00, 3, 0);

        // Fill the stack, then overflow it.
        for (int i = 0; i < STACK_DEPTH; i++) run_instr("push", I_PUSH, 4'b0110, 8'h00, 0, 0);
        run_instr("ovf", I_PUSH, 4'b0110, 8'h00, 0, 1);
        run_instr("post_ovf", I_PLAIN, 4'b0110, 8'h00, 0, 0);

        // Reset asserted in the middle of a multiply wait.
        cond_code = 4'b0110;
        drive_instr(I_MUL);
        mem_ready = 1'b1;
        step("rstmul/fetch", S_FETCH, 1'b1, 1'b0);
        mem_ready = 1'b0;
        step("rstmul/exec1", S_EXEC1, 1'b0, 1'b0);
        step("rstmul/mulw",  S_MULW,  1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmul:state",  state,      S_FETCH);
        check("rstmul:sp",     sp,         0);
        check("rstmul:commit", commit,     0);
        check("rstmul:busy",   mul_busy,   0);
        check("rstmul:cause",  halt_cause, 0);
        m_sp    = 0;
        m_cause = 0;
        drive_instr(I_PLAIN);
        @(negedge clk);
        check("rstmul:commit2", commit, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       ins = I_PLAIN;
                1:       ins = I_EXT;
                2:       ins = I_MUL;
                3:       ins = I_PUSH;
                4:       ins = I_CALL;
                5:       ins = I_POP;
                6:       ins = I_RTN;
                7:       ins = I_STP;
                8:       ins = I_EXT | I_PUSH;
                default: ins = I_EXT | I_MUL;
            endcase
            run_instr("rnd", ins, 4'($urandom), 8'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
